// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic array input-FIFO controllers.
package systolic_pkg;

   localparam int unsigned ARRAY_DIM = 4;
   localparam int unsigned DATA_W    = 16;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      FEED = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sa_skew_gen.sv
// Diagonal skew pattern: FIFO i shifts for array_dim consecutive steps starting at step i.
module sa_skew_gen #(
   parameter int unsigned array_dim = 4,
   parameter int unsigned cnt_w     = 3
) (
   input  logic [cnt_w-1:0]     feed_cnt,
   input  logic                 en,
   output logic [array_dim-1:0] shift
);

   always_comb begin
      shift = '0;
      for (int i = 0; i < int'(array_dim); i++) begin
         shift[i] = en && (int'(feed_cnt) >= i) && (int'(feed_cnt) < i + int'(array_dim));
      end
   end

endmodule

// File: rtl/systolic_fifo_ctrl.sv
// Row loader and skewed-drain sequencer for the per-row systolic input FIFOs.
// Optional stall counter enabled by defining SA_FIFO_CTRL_PERF_EN.
module systolic_fifo_ctrl
   import systolic_pkg::*;
#(
   parameter int unsigned array_dim = ARRAY_DIM,
   parameter int unsigned data_w    = DATA_W
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        row_valid,
   output logic                        row_ready,
   input  logic [data_w*array_dim-1:0] row_data,
   input  logic                        stall,
   input  logic                        flush,
   output logic [array_dim-1:0]        load,
   output logic [data_w*array_dim-1:0] load_values,
   output logic [array_dim-1:0]        shift,
   output logic                        busy,
   output logic                        done
`ifdef SA_FIFO_CTRL_PERF_EN
   ,
   output logic [15:0]                 stall_cycles
`endif
);

   localparam int unsigned RW = $clog2(array_dim);
   localparam int unsigned FW = $clog2(2 * array_dim);

   state_t          state_q, state_d;
   logic [RW-1:0]   row_cnt_q, row_cnt_d;
   logic [FW-1:0]   feed_cnt_q, feed_cnt_d;
   logic            shift_en;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= LOAD;
         row_cnt_q  <= '0;
         feed_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         feed_cnt_q <= feed_cnt_d;
      end
   end

   // Next state and strobes; flush overrides every other event in the cycle.
   always_comb begin
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      feed_cnt_d = feed_cnt_q;
      row_ready  = 1'b0;
      load       = '0;
      shift_en   = 1'b0;
      busy       = 1'b0;

      unique case (state_q)
         LOAD: begin
            row_ready = ~flush;
            if (row_valid && !flush) begin
               load[row_cnt_q] = 1'b1;
               if (row_cnt_q == RW'(array_dim - 1)) begin
                  state_d    = FEED;
                  row_cnt_d  = '0;
                  feed_cnt_d = '0;
               end else begin
                  row_cnt_d = row_cnt_q + RW'(1);
               end
            end
         end
         FEED: begin
            busy = 1'b1;
            if (!stall && !flush) begin
               shift_en   = 1'b1;
               feed_cnt_d = feed_cnt_q + FW'(1);
               if (feed_cnt_q == FW'(2 * array_dim - 2)) begin
                  state_d    = DONE;
                  feed_cnt_d = '0;
               end
            end
         end
         DONE: state_d = LOAD;
         default: state_d = LOAD;
      endcase

      if (flush) begin
         state_d    = LOAD;
         row_cnt_d  = '0;
         feed_cnt_d = '0;
      end
   end

   assign done        = (state_q == DONE);
   assign load_values = row_data;

   sa_skew_gen #(
      .array_dim (array_dim),
      .cnt_w     (FW)
   ) u_skew (
      .feed_cnt (feed_cnt_q),
      .en       (shift_en),
      .shift    (shift)
   );

`ifdef SA_FIFO_CTRL_PERF_EN
   // Saturating count of stalled feed cycles; only reset clears it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cycles <= '0;
      end else if (state_q == FEED && stall && stall_cycles != 16'hFFFF) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_fifo_ctrl.sv
// Randomized and directed bench for systolic_fifo_ctrl against a phase/step reference model.
module tb_systolic_fifo_ctrl;

   localparam int D = 4;
   localparam int W = 16;
   localparam int OW = 2 * D + 3;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             row_valid;
   logic             row_ready;
   logic [W*D-1:0]   row_data;
   logic             stall;
   logic             flush;
   logic [D-1:0]     load;
   logic [W*D-1:0]   load_values;
   logic [D-1:0]     shift;
   logic             busy;
   logic             done;
`ifdef SA_FIFO_CTRL_PERF_EN
   logic [15:0]      stall_cycles;
`endif

   systolic_fifo_ctrl #(.array_dim(D), .data_w(W)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .row_valid   (row_valid),
      .row_ready   (row_ready),
      .row_data    (row_data),
      .stall       (stall),
      .flush       (flush),
      .load        (load),
      .load_values (load_values),
      .shift       (shift),
      .busy        (busy),
      .done        (done)
`ifdef SA_FIFO_CTRL_PERF_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: phase 0=loading, 1=feeding, 2=done; rows accepted; feed steps taken.
   int m_phase = 0;
   int m_rows  = 0;
   int m_step  = 0;
   int m_perf  = 0;

   logic [D-1:0] shift_tbl [7];
   initial begin
      shift_tbl[0] = 4'b0001; shift_tbl[1] = 4'b0011; shift_tbl[2] = 4'b0111;
      shift_tbl[3] = 4'b1111; shift_tbl[4] = 4'b1110; shift_tbl[5] = 4'b1100;
      shift_tbl[6] = 4'b1000;
   end

   function automatic logic [OW-1:0] model_exp(input logic v, input logic s, input logic f);
      logic rr, bz, dn;
      logic [D-1:0] ld, sh;
      rr = (m_phase == 0) && !f;
      bz = (m_phase == 1);
      dn = (m_phase == 2);
      ld = '0;
      sh = '0;
      if (m_phase == 0 && v && !f) ld[m_rows] = 1'b1;
      if (m_phase == 1 && !s && !f)
         for (int i = 0; i < D; i++) sh[i] = (m_step >= i) && (m_step < i + D);
      return {rr, bz, dn, ld, sh};
   endfunction

   function automatic logic [OW-1:0] dut_obs();
      return {row_ready, busy, done, load, shift};
   endfunction

   task automatic model_adv(input logic v, input logic s, input logic f);
      if (m_phase == 1 && s && m_perf < 65535) m_perf++;
      if (f) begin
         m_phase = 0; m_rows = 0; m_step = 0;
      end else begin
         case (m_phase)
            0: if (v) begin
                  m_rows++;
                  if (m_rows == D) begin m_phase = 1; m_rows = 0; m_step = 0; end
               end
            1: if (!s) begin
                  m_step++;
                  if (m_step == 2 * D - 1) begin m_phase = 2; m_step = 0; end
               end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic apply(input logic v, input logic s, input logic f);
      @(negedge CLK);
      row_valid = v;
      stall     = s;
      flush     = f;
      row_data  = {$urandom, $urandom};
      #2;
   endtask

   task automatic tick(input logic v, input logic s, input logic f);
      @(posedge CLK);
      model_adv(v, s, f);
   endtask

   task automatic test_reset();
      nRST = 1'b0; row_valid = 1'b0; stall = 1'b0; flush = 1'b0; row_data = '0;
      #12;
      n_vec++;
      if (dut_obs() !== {1'b1, 1'b0, 1'b0, {D{1'b0}}, {D{1'b0}}}) begin
         n_err++;
         $display("FAIL reset_outputs got=%b want=%b", dut_obs(), {1'b1, 1'b0, 1'b0, {D{1'b0}}, {D{1'b0}}});
      end
`ifdef SA_FIFO_CTRL_PERF_EN
      n_vec++;
      if (stall_cycles !== 16'd0) begin
         n_err++; $display("FAIL reset_stall_cycles got=%0d want=0", stall_cycles);
      end
`endif
      @(negedge CLK);
      nRST = 1'b1;
      m_phase = 0; m_rows = 0; m_step = 0; m_perf = 0;
   endtask

   task automatic test_back_to_back();
      logic v;
      logic [OW-1:0] e;
      for (int c = 0; c <= 12; c++) begin
         v = (c < 4);
         apply(v, 1'b0, 1'b0);
         e = model_exp(v, 1'b0, 1'b0);
         n_vec++;
         if (dut_obs() !== e) begin n_err++; $display("FAIL b2b_model c=%0d got=%b want=%b", c, dut_obs(), e); end
         if (c < 4 && (load !== D'(1 << c) || load_values !== row_data)) begin
            n_err++; $display("FAIL b2b_load c=%0d got=%b want=%b", c, load, D'(1 << c));
         end
         if (c >= 4 && c <= 10 && shift !== shift_tbl[c-4]) begin
            n_err++; $display("FAIL b2b_shift c=%0d got=%b want=%b", c, shift, shift_tbl[c-4]);
         end
         if (c == 11 && done !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%b want=1", done); end
         if (c == 12 && row_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b want=1", row_ready); end
         tick(v, 1'b0, 1'b0);
      end
   endtask

   task automatic test_sparse();
      logic v;
      logic [OW-1:0] e;
      for (int c = 0; c < 20; c++) begin
         v = (c % 3 == 0) && (c < 12);
         apply(v, 1'b0, 1'b0);
         e = model_exp(v, 1'b0, 1'b0);
         n_vec++;
         if (dut_obs() !== e) begin n_err++; $display("FAIL sparse c=%0d got=%b want=%b", c, dut_obs(), e); end
         if (c == 17 && done !== 1'b1) begin n_err++; $display("FAIL sparse_done got=%b want=1", done); end
         tick(v, 1'b0, 1'b0);
      end
   endtask

   task automatic test_stall();
      logic v, s;
      logic [OW-1:0] e;
      for (int c = 0; c < 15; c++) begin
         v = (c < 4);
         s = (c == 7 || c == 8);
         apply(v, s, 1'b0);
         e = model_exp(v, s, 1'b0);
         n_vec++;
         if (dut_obs() !== e) begin n_err++; $display("FAIL stall c=%0d got=%b want=%b", c, dut_obs(), e); end
         if (s && shift !== '0) begin n_err++; $display("FAIL stall_zero c=%0d got=%b want=0", c, shift); end
         if (c == 9 && shift !== 4'b1111) begin n_err++; $display("FAIL stall_resume got=%b want=1111", shift); end
         if (c == 13 && done !== 1'b1) begin n_err++; $display("FAIL stall_done got=%b want=1", done); end
         tick(v, s, 1'b0);
      end
`ifdef SA_FIFO_CTRL_PERF_EN
      #1;
      n_vec++;
      if (int'(stall_cycles) !== m_perf) begin
         n_err++; $display("FAIL stall_cycles got=%0d want=%0d", stall_cycles, m_perf);
      end
`endif
   endtask

   task automatic test_flush_feed();
      logic v, f;
      logic [OW-1:0] e;
      for (int c = 0; c < 20; c++) begin
         v = (c < 4) || (c >= 7 && c < 11);
         f = (c == 6);
         apply(v, 1'b0, f);
         e = model_exp(v, 1'b0, f);
         n_vec++;
         if (dut_obs() !== e) begin n_err++; $display("FAIL flush_feed c=%0d got=%b want=%b", c, dut_obs(), e); end
         if (c == 6 && shift !== '0) begin n_err++; $display("FAIL flush_shift got=%b want=0", shift); end
         if (c == 7 && (row_ready !== 1'b1 || busy !== 1'b0)) begin
            n_err++; $display("FAIL flush_to_load rr=%b busy=%b want rr=1 busy=0", row_ready, busy);
         end
         if (c < 18 && done !== 1'b0) begin n_err++; $display("FAIL flush_nodone c=%0d got=%b want=0", c, done); end
         if (c == 18 && done !== 1'b1) begin n_err++; $display("FAIL flush_reload_done got=%b want=1", done); end
         tick(v, 1'b0, f);
      end
   endtask

   task automatic test_flush_load();
      logic v, f;
      logic [OW-1:0] e;
      for (int c = 0; c < 14; c++) begin
         v = (c < 5);
         f = (c == 0);
         apply(v, 1'b0, f);
         e = model_exp(v, 1'b0, f);
         n_vec++;
         if (dut_obs() !== e) begin n_err++; $display("FAIL flush_load c=%0d got=%b want=%b", c, dut_obs(), e); end
         if (c == 0 && (load !== '0 || row_ready !== 1'b0)) begin
            n_err++; $display("FAIL flush_load_block load=%b rr=%b want 0 0", load, row_ready);
         end
         if (c == 1 && load !== 4'b0001) begin n_err++; $display("FAIL flush_load_cnt got=%b want=0001", load); end
         tick(v, 1'b0, f);
      end
   endtask

   task automatic test_reset_mid_feed();
      logic v;
      logic [OW-1:0] e;
      for (int c = 0; c < 7; c++) begin
         v = (c < 4);
         apply(v, 1'b0, 1'b0);
         tick(v, 1'b0, 1'b0);
      end
      apply(1'b0, 1'b0, 1'b0);
      nRST = 1'b0;
      #1;
      n_vec++;
      if (dut_obs() !== {1'b1, 1'b0, 1'b0, {D{1'b0}}, {D{1'b0}}}) begin
         n_err++; $display("FAIL rst_mid_feed got=%b want=%b", dut_obs(), {1'b1, 1'b0, 1'b0, {D{1'b0}}, {D{1'b0}}});
      end
      @(negedge CLK);
      nRST = 1'b1;
      m_phase = 0; m_rows = 0; m_step = 0; m_perf = 0;
      for (int c = 0; c < 13; c++) begin
         v = (c < 4);
         apply(v, 1'b0, 1'b0);
         e = model_exp(v, 1'b0, 1'b0);
         n_vec++;
         if (dut_obs() !== e) begin n_err++; $display("FAIL rst_recover c=%0d got=%b want=%b", c, dut_obs(), e); end
         tick(v, 1'b0, 1'b0);
      end
   endtask

   task automatic test_random();
      logic v, s, f;
      logic [OW-1:0] e;
      for (int c = 0; c < 800; c++) begin
         v = ($urandom % 3) != 0;
         s = ($urandom % 4) == 0;
         f = ($urandom % 32) == 0;
         apply(v, s, f);
         e = model_exp(v, s, f);
         n_vec++;
         if (dut_obs() !== e || load_values !== row_data) begin
            n_err++; $display("FAIL random c=%0d got=%b want=%b", c, dut_obs(), e);
         end
         tick(v, s, f);
      end
`ifdef SA_FIFO_CTRL_PERF_EN
      #1;
      n_vec++;
      if (int'(stall_cycles) !== m_perf) begin
         n_err++; $display("FAIL random_stall_cycles got=%0d want=%0d", stall_cycles, m_perf);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_sparse();
      test_stall();
      test_flush_feed();
      test_flush_load();
      test_reset_mid_feed();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
